mdu_iterative: RTL and testbench
================================

// Module: mdu_iterative
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EX stage; full RV M-extension op set
//  (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) behind one shared FSM.
//  Valid/ready on both input and output; flush input for pipeline kills.
//  Configurable bits-per-cycle for mul and div; RISC-V special cases resolved without iterating.
// PARAMETERS
//  XLEN       32  operand/result width
//  MUL_BPC     4  multiplier bits retired per cycle; must divide XLEN
//  DIV_BPC     1  quotient bits retired per cycle (1 or 2); must divide XLEN
// PORTS
//  clk        in   1            clock
//  reset_n    in   1            reset, synchronous, active-low
//  flush      in   1            kill in-flight op
//  in_valid   in   1            request valid
//  in_ready   out  1            unit can accept a request (state IDLE)
//  op         in   alu_op_type  operation; non-M ops complete with result 0
//  operand1   in   XLEN         rs1 value (dividend / multiplicand)
//  operand2   in   XLEN         rs2 value (divisor / multiplier)
//  out_valid  out  1            result valid
//  out_ready  in   1            consumer accepts result
//  result     out  XLEN         result
//  exception  out  1            divide-by-zero flag, qualified by out_valid
//  busy       out  1            state != IDLE
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state IDLE; out_valid=0, result=0, exception=0, busy=0, in_ready=1.
//   Reset mid-operation abandons the op; no result is produced.
//  FSM: IDLE -> (in_valid&in_ready) -> MUL | DIV | DONE(special/non-M);
//   MUL -> DONE after XLEN/MUL_BPC iterations; DIV -> FIX after XLEN/DIV_BPC iterations;
//   FIX (sign correction of quotient/remainder) -> DONE; DONE -> IDLE on out_ready.
//  Latency, accept in cycle k: mul out_valid at k+XLEN/MUL_BPC+1; div at k+XLEN/DIV_BPC+2;
//   special cases and non-M ops at k+1.
//  Operands and op are captured at accept; input changes afterwards are ignored.
//  Mul: operands sign/zero-extended to 2*XLEN per op (MULHSU: rs1 signed, rs2 unsigned);
//   MUL returns product[XLEN-1:0], MULH* return product[2XLEN-1:XLEN].
//  Div: magnitudes divided unsigned (restoring); quotient negated if signs differ (DIV);
//   remainder takes dividend sign (REM).
//  Divide by zero: quotient all-ones, remainder = operand1, exception=1, 1-cycle path.
//  Signed overflow (operand1 = most negative, operand2 = -1, DIV/REM): quotient = operand1,
//   remainder 0, exception=0, 1-cycle path.
//  Output held stable while out_valid & !out_ready; in_ready=0 until DONE is left.
//   No accept in the same cycle as the DONE->IDLE handoff.
//  flush: next cycle state IDLE, out_valid=0; flush beats in_valid in the same cycle
//   (no accept). Flush in DONE discards the result.
// CONFIGURATION
//  MDU_EARLY_OUT_EN defined: MUL leaves the loop when the remaining unshifted multiplier bits
//   are all zero (signed ops: all equal to the sign bit after correction term is applied);
//   latency = ceil(significant_bits/MUL_BPC)+1, minimum k+2. Div latency unchanged.
//  Undefined: fixed latency as above; the early-out comparator is absent.
// STRUCTURE
//  common package: alu_op_type including ALU_MULHSU, ALU_MULHU; XLEN_WIDTH default;
//   mdu_state_t enum (IDLE, MUL, DIV, FIX, DONE).
//  Sub-module mdu_div_step: combinational DIV_BPC-bit restoring step
//   (partial remainder, divisor -> next remainder, quotient bits).
//  Multiplier datapath and FSM stay in this module.
// TESTING
//  Reset: hold reset_n=0 2 cycles mid-DIV -> out_valid=0, in_ready=1 next cycle; no stale result.
//  MUL 0x0000_0007*0xFFFF_FFFD (XLEN=32, MUL_BPC=4) -> 0xFFFF_FFEB at k+9;
//   MULH same operands -> 0xFFFF_FFFF; MULHU -> 0x0000_0006.
//  DIV -7/2 -> 0xFFFF_FFFD, REM -> 0xFFFF_FFFF, DIVU 100/7 -> 14 at k+34.
//  DIV 5/0 -> 0xFFFF_FFFF, exception=1 at k+1; REMU 5/0 -> 5, exception=1.
//  DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000, REM -> 0, exception=0 at k+1.
//  Backpressure: out_ready=0 for 5 cycles -> result stable, in_ready=0; flush mid-MUL with
//   in_valid=1 same cycle -> no accept, IDLE next cycle, out_valid never set.

Source files
------------

// File: rtl/mdu_iterative_pkg.sv
// -----------------------------------------------------------------------------
// mdu_iterative_pkg
//   Shared types for the iterative multiply/divide unit:
//     alu_op_type  - EX-stage ALU operation code (base ops plus RV M-extension)
//     mdu_state_t  - control FSM states of mdu_iterative
//     XLEN_WIDTH   - default operand/result width
//   Helper functions classify an op as multiply, divide, signed divide or
//   remainder.
// -----------------------------------------------------------------------------
package mdu_iterative_pkg;

   localparam int XLEN_WIDTH = 32;

   typedef enum logic [4:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_MUL,
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU,
      ALU_DIV,
      ALU_DIVU,
      ALU_REM,
      ALU_REMU
   } alu_op_type;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      FIX,
      DONE
   } mdu_state_t;

   function automatic logic is_mul_op(input alu_op_type o);
      return o inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
   endfunction

   function automatic logic is_div_op(input alu_op_type o);
      return o inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   endfunction

   function automatic logic is_signed_div_op(input alu_op_type o);
      return o inside {ALU_DIV, ALU_REM};
   endfunction

   function automatic logic is_rem_op(input alu_op_type o);
      return o inside {ALU_REM, ALU_REMU};
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// -----------------------------------------------------------------------------
// mdu_div_step
//   Combinational restoring-division step retiring DIV_BPC quotient bits.
//   The quotient register doubles as the dividend shift register: dividend
//   bits leave at the top while quotient bits enter at the bottom.
// Ports
//   rem_in   in   XLEN  partial remainder (always < divisor)
//   quo_in   in   XLEN  remaining dividend bits / quotient bits so far
//   divisor  in   XLEN  divisor magnitude
//   rem_out  out  XLEN  partial remainder after DIV_BPC steps
//   quo_out  out  XLEN  shift register after DIV_BPC steps
// -----------------------------------------------------------------------------
module mdu_div_step #(
   parameter int XLEN    = 32,
   parameter int DIV_BPC = 1
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] quo_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] quo_out
);

   logic [XLEN-1:0] rem_chain [DIV_BPC+1];
   logic [XLEN-1:0] quo_chain [DIV_BPC+1];

   assign rem_chain[0] = rem_in;
   assign quo_chain[0] = quo_in;

   for (genvar gi = 0; gi < DIV_BPC; gi++) begin : g_bit
      logic [XLEN:0] trial;
      logic [XLEN:0] diff;
      logic          fits;

      assign trial = {rem_chain[gi], quo_chain[gi][XLEN-1]};
      assign diff  = trial - {1'b0, divisor};
      // Since rem < divisor, trial < 2*divisor: a clear top bit of the
      // (XLEN+1)-bit difference means no borrow, i.e. trial >= divisor.
      assign fits  = ~diff[XLEN];
      assign rem_chain[gi+1] = fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
      assign quo_chain[gi+1] = {quo_chain[gi][XLEN-2:0], fits};
   end

   assign rem_out = rem_chain[DIV_BPC];
   assign quo_out = quo_chain[DIV_BPC];

endmodule

// File: rtl/mdu_iterative.sv
// -----------------------------------------------------------------------------
// mdu_iterative
//   Iterative multiply/divide unit for the EX stage covering MUL, MULH,
//   MULHSU, MULHU, DIV, DIVU, REM and REMU behind one control FSM.
//   Multiply retires MUL_BPC multiplier bits per cycle, divide retires
//   DIV_BPC quotient bits per cycle (restoring, on magnitudes) followed by a
//   sign-fix cycle. Divide-by-zero, signed overflow and non-M ops finish in
//   one cycle without iterating.
//   Optional build macro MDU_EARLY_OUT_EN: multiply leaves its loop as soon
//   as the remaining multiplier bits are all zero.
// Ports
//   clk        in   1      clock
//   reset_n    in   1      synchronous active-low reset
//   flush      in   1      kill in-flight op (wins over in_valid)
//   in_valid   in   1      request valid
//   in_ready   out  1      unit idle and able to accept
//   op         in   alu_op_type operation
//   operand1   in   XLEN   rs1 (multiplicand / dividend)
//   operand2   in   XLEN   rs2 (multiplier / divisor)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   result     out  XLEN   result
//   exception  out  1      divide-by-zero, qualified by out_valid
//   busy       out  1      state != IDLE
// -----------------------------------------------------------------------------
module mdu_iterative
   import mdu_iterative_pkg::*;
#(
   parameter int XLEN    = XLEN_WIDTH,
   parameter int MUL_BPC = 4,
   parameter int DIV_BPC = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  alu_op_type      op,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            exception,
   output logic            busy
);

   localparam int MUL_ITERS = XLEN / MUL_BPC;
   localparam int DIV_ITERS = XLEN / DIV_BPC;
   localparam int MAX_ITERS = (MUL_ITERS > DIV_ITERS) ? MUL_ITERS : DIV_ITERS;
   localparam int CNT_W     = $clog2(MAX_ITERS) + 1;
   localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_ITERS - 1);
   localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_ITERS - 1);
   localparam logic [XLEN-1:0]  XLEN_MIN     = {1'b1, {(XLEN-1){1'b0}}};

   // ---------------------------------------------------------------- state
   mdu_state_t state_reg, state_next;

   logic [CNT_W-1:0]  cnt_reg;
   logic [2*XLEN-1:0] mcand_reg;
   logic [XLEN-1:0]   mplier_reg;
   logic [2*XLEN-1:0] acc_reg;
   logic [XLEN-1:0]   rem_reg;
   logic [XLEN-1:0]   quo_reg;
   logic [XLEN-1:0]   dvsr_reg;
   logic              mul_low_reg;
   logic              rem_sel_reg;
   logic              neg_q_reg;
   logic              neg_r_reg;
   logic [XLEN-1:0]   result_reg;
   logic              exc_reg;

   // -------------------------------------------------- request decode
   logic              op_mul;
   logic              op_div;
   logic              op_div_signed;
   logic              op_rem;
   logic              div_by_zero;
   logic              div_ovf;
   logic              div_special;
   logic              accept;
   logic              rs1_signed;
   logic              rs2_signed;
   logic [2*XLEN-1:0] mcand_init;
   logic [2*XLEN-1:0] acc_init;
   logic [XLEN-1:0]   op1_mag;
   logic [XLEN-1:0]   op2_mag;

   always_comb begin
      op_mul        = is_mul_op(op);
      op_div        = is_div_op(op);
      op_div_signed = is_signed_div_op(op);
      op_rem        = is_rem_op(op);
      div_by_zero   = (operand2 == '0);
      div_ovf       = op_div_signed && (operand1 == XLEN_MIN) && (operand2 == '1);
      div_special   = op_div && (div_by_zero || div_ovf);
      accept        = (state_reg == IDLE) && in_valid && !flush;

      rs1_signed    = (op == ALU_MULH) || (op == ALU_MULHSU);
      rs2_signed    = (op == ALU_MULH);
      mcand_init    = {{XLEN{rs1_signed & operand1[XLEN-1]}}, operand1};
      // The multiplier is iterated as an unsigned XLEN-bit value; a negative
      // signed multiplier is corrected up front by pre-loading the
      // accumulator with -(multiplicand << XLEN).
      acc_init      = (rs2_signed && operand2[XLEN-1]) ?
                      ('0 - {operand1, {XLEN{1'b0}}}) : '0;

      op1_mag = (op_div_signed && operand1[XLEN-1]) ? (~operand1 + 1'b1) : operand1;
      op2_mag = (op_div_signed && operand2[XLEN-1]) ? (~operand2 + 1'b1) : operand2;
   end

   // ------------------------------------------------ multiplier datapath
   logic [2*XLEN-1:0] pp_terms [MUL_BPC];
   logic [2*XLEN-1:0] pp_sum;
   logic [2*XLEN-1:0] acc_step;
   logic [XLEN-1:0]   mplier_next;
   logic              mul_last;

   for (genvar gi = 0; gi < MUL_BPC; gi++) begin : g_pp
      assign pp_terms[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
   end

   always_comb begin
      pp_sum = '0;
      for (int i = 0; i < MUL_BPC; i++) begin
         pp_sum = pp_sum + pp_terms[i];
      end
   end

   assign acc_step    = acc_reg + pp_sum;
   assign mplier_next = mplier_reg >> MUL_BPC;

`ifdef MDU_EARLY_OUT_EN
   // Leave the loop once no multiplier bits remain to be added.
   assign mul_last = (cnt_reg == '0) || (mplier_next == '0);
`else
   assign mul_last = (cnt_reg == '0);
`endif

   // --------------------------------------------------- divider datapath
   logic [XLEN-1:0] rem_step;
   logic [XLEN-1:0] quo_step;
   logic [XLEN-1:0] fix_result;

   mdu_div_step #(
      .XLEN    (XLEN),
      .DIV_BPC (DIV_BPC)
   ) u_div_step (
      .rem_in  (rem_reg),
      .quo_in  (quo_reg),
      .divisor (dvsr_reg),
      .rem_out (rem_step),
      .quo_out (quo_step)
   );

   always_comb begin
      fix_result = '0;
      if (rem_sel_reg) begin
         fix_result = neg_r_reg ? ('0 - rem_reg) : rem_reg;
      end else begin
         fix_result = neg_q_reg ? ('0 - quo_reg) : quo_reg;
      end
   end

   // -------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      busy       = 1'b1;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               if (op_mul) begin
                  state_next = MUL;
               end else if (op_div && !div_special) begin
                  state_next = DIV;
               end else begin
                  state_next = DONE;
               end
            end
         end
         MUL: begin
            if (mul_last) begin
               state_next = DONE;
            end
         end
         DIV: begin
            if (cnt_reg == '0) begin
               state_next = FIX;
            end
         end
         FIX: begin
            state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (flush) begin
         state_next = IDLE;
      end
   end

   assign exception = out_valid & exc_reg;
   assign result    = result_reg;

   // ------------------------------------------------- datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_reg     <= '0;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         acc_reg     <= '0;
         rem_reg     <= '0;
         quo_reg     <= '0;
         dvsr_reg    <= '0;
         mul_low_reg <= 1'b0;
         rem_sel_reg <= 1'b0;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
         result_reg  <= '0;
         exc_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  mcand_reg   <= mcand_init;
                  mplier_reg  <= operand2;
                  acc_reg     <= acc_init;
                  rem_reg     <= '0;
                  quo_reg     <= op1_mag;
                  dvsr_reg    <= op2_mag;
                  mul_low_reg <= (op == ALU_MUL);
                  rem_sel_reg <= op_rem;
                  neg_q_reg   <= op_div_signed && (operand1[XLEN-1] ^ operand2[XLEN-1]);
                  neg_r_reg   <= op_div_signed && operand1[XLEN-1];
                  cnt_reg     <= op_mul ? MUL_CNT_INIT : DIV_CNT_INIT;
                  result_reg  <= '0;
                  exc_reg     <= 1'b0;
                  if (op_div && div_by_zero) begin
                     result_reg <= op_rem ? operand1 : '1;
                     exc_reg    <= 1'b1;
                  end else if (div_ovf) begin
                     result_reg <= op_rem ? '0 : operand1;
                  end
               end
            end
            MUL: begin
               acc_reg    <= acc_step;
               mcand_reg  <= mcand_reg << MUL_BPC;
               mplier_reg <= mplier_next;
               cnt_reg    <= cnt_reg - 1'b1;
               if (mul_last) begin
                  result_reg <= mul_low_reg ? acc_step[XLEN-1:0] : acc_step[2*XLEN-1:XLEN];
               end
            end
            DIV: begin
               rem_reg <= rem_step;
               quo_reg <= quo_step;
               cnt_reg <= cnt_reg - 1'b1;
            end
            FIX: begin
               result_reg <= fix_result;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iterative.sv
// -----------------------------------------------------------------------------
// tb_mdu_iterative
//   Directed bench for mdu_iterative (XLEN=32, MUL_BPC=4, DIV_BPC=1).
//   A vector table covers the op set, RISC-V special cases and latencies;
//   hand-written sequences cover reset mid-divide, backpressure and flush.
// -----------------------------------------------------------------------------
module tb_mdu_iterative;
   import mdu_iterative_pkg::*;

   localparam int LAT_MUL = 9;
   localparam int LAT_DIV = 34;
   localparam int LAT_SPC = 1;
   localparam int NVEC    = 20;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   alu_op_type  op;
   logic [31:0] operand1;
   logic [31:0] operand2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        exception;
   logic        busy;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      alu_op_type  vop;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        exc;
      int          lat;
   } vec_t;

   vec_t vecs [NVEC];

   mdu_iterative #(
      .XLEN    (32),
      .MUL_BPC (4),
      .DIV_BPC (1)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .operand1  (operand1),
      .operand2  (operand2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .exception (exception),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_lat(input string name, input int act, input int exp);
`ifdef MDU_EARLY_OUT_EN
      if (exp == LAT_MUL) begin
         check(name, 32'(act <= exp), 32'd1);
      end else begin
         check(name, 32'(act), 32'(exp));
      end
`else
      check(name, 32'(act), 32'(exp));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and wait for its result. Called #1 after a posedge.
   task automatic do_op(input alu_op_type o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic e, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 100) begin
         tick();
         guard++;
      end
      op       = o;
      operand1 = a;
      operand2 = b;
      in_valid = 1'b1;
      tick();
      // Scramble the inputs: the unit must have captured them at accept.
      in_valid = 1'b0;
      op       = ALU_ADD;
      operand1 = ~a;
      operand2 = ~b;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      r = result;
      e = exception;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic        e;
      int          lat;
      int          seen;

      vecs[0]  = '{ALU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, LAT_MUL};
      vecs[1]  = '{ALU_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT_MUL};
      vecs[2]  = '{ALU_MULHU,  32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 1'b0, LAT_MUL};
      vecs[3]  = '{ALU_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, LAT_MUL};
      vecs[4]  = '{ALU_MULHSU, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, LAT_MUL};
      vecs[5]  = '{ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, LAT_MUL};
      vecs[6]  = '{ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, LAT_MUL};
      vecs[7]  = '{ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, LAT_MUL};
      vecs[8]  = '{ALU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, LAT_DIV};
      vecs[9]  = '{ALU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, LAT_DIV};
      vecs[10] = '{ALU_DIVU,   32'd100,       32'd7,         32'd14,        1'b0, LAT_DIV};
      vecs[11] = '{ALU_REMU,   32'd100,       32'd7,         32'd2,         1'b0, LAT_DIV};
      vecs[12] = '{ALU_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, LAT_DIV};
      vecs[13] = '{ALU_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT_DIV};
      vecs[14] = '{ALU_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, LAT_DIV};
      vecs[15] = '{ALU_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, LAT_SPC};
      vecs[16] = '{ALU_REMU,   32'd5,         32'd0,         32'h0000_0005, 1'b1, LAT_SPC};
      vecs[17] = '{ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, LAT_SPC};
      vecs[18] = '{ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, LAT_SPC};
      vecs[19] = '{ALU_ADD,    32'd3,         32'd4,         32'h0000_0000, 1'b0, LAT_SPC};

      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      op        = ALU_ADD;
      operand1  = '0;
      operand2  = '0;
      out_ready = 1'b1;

      // ---- reset state
      tick();
      tick();
      reset_n = 1'b1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_result",    result,         32'd0);
      check("rst_exception", 32'(exception), 32'd0);
      $display("[TB] reset state checked");

      // ---- vector table
      for (int i = 0; i < NVEC; i++) begin
         do_op(vecs[i].vop, vecs[i].a, vecs[i].b, r, e, lat);
         check_lat($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d_result", i), r, vecs[i].res);
         check($sformatf("vec%0d_exception", i), 32'(e), 32'(vecs[i].exc));
         $display("[TB] vec %0d %s a=%h b=%h -> result=%h exc=%0d lat=%0d",
                  i, vecs[i].vop.name(), vecs[i].a, vecs[i].b, r, e, lat);
      end
      tick();

      // ---- reset held 2 cycles in the middle of a divide
      op = ALU_DIVU; operand1 = 32'd100; operand2 = 32'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      check("midrst_busy",      32'(busy),      32'd0);
      check("midrst_result",    result,         32'd0);
      seen = 0;
      repeat (40) begin
         tick();
         if (out_valid) seen++;
      end
      check("midrst_no_stale", 32'(seen), 32'd0);
      $display("[TB] reset mid-DIV: out_valid cycles afterwards=%0d", seen);

      // ---- backpressure: result held, in_ready low, no accept on handoff
      out_ready = 1'b0;
      do_op(ALU_MUL, 32'h0000_0007, 32'hFFFF_FFFD, r, e, lat);
      check_lat("bp_latency", lat, LAT_MUL);
      check("bp_first_result", r, 32'hFFFF_FFEB);
      op = ALU_MULHU; operand1 = 32'h0000_0007; operand2 = 32'hFFFF_FFFD; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_result", result,         32'hFFFF_FFEB);
         check("bp_hold_valid",  32'(out_valid), 32'd1);
         check("bp_in_ready",    32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      tick();
      check("bp_handoff_valid", 32'(out_valid), 32'd0);
      check("bp_handoff_ready", 32'(in_ready),  32'd1);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check_lat("bp_next_latency", lat, LAT_MUL);
      check("bp_next_result", result, 32'h0000_0006);
      $display("[TB] backpressure: held 5 cycles, next MULHU result=%h lat=%0d", result, lat);
      tick();

      // ---- flush mid-MUL with in_valid in the same cycle
      op = ALU_MUL; operand1 = 32'd3; operand2 = 32'd5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check("flush_busy_before", 32'(busy), 32'd1);
      flush = 1'b1; in_valid = 1'b1; op = ALU_DIV; operand1 = 32'd5; operand2 = 32'd0;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_busy",      32'(busy),      32'd0);
      check("flush_in_ready",  32'(in_ready),  32'd1);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      seen = 0;
      repeat (15) begin
         tick();
         if (out_valid) seen++;
      end
      check("flush_no_result", 32'(seen), 32'd0);
      $display("[TB] flush mid-MUL: out_valid cycles afterwards=%0d", seen);

      // ---- flush in IDLE beats a same-cycle request
      flush = 1'b1; in_valid = 1'b1; op = ALU_DIV; operand1 = 32'd5; operand2 = 32'd0;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_idle_busy",  32'(busy),      32'd0);
      check("flush_idle_valid", 32'(out_valid), 32'd0);
      $display("[TB] flush in IDLE with in_valid: busy=%0d", busy);

      // ---- flush in DONE discards the result
      out_ready = 1'b0;
      do_op(ALU_DIV, 32'd5, 32'd0, r, e, lat);
      check("flush_done_valid_before", 32'(out_valid), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      out_ready = 1'b1;
      check("flush_done_valid", 32'(out_valid), 32'd0);
      check("flush_done_ready", 32'(in_ready),  32'd1);
      $display("[TB] flush in DONE: out_valid=%0d", out_valid);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
